// File: rtl/iec_bus_hub.sv
// IEC serial-bus hub: open-collector wired-AND of host and drive pulls with ATN auto-ack,
// synchronised/glitch-filtered line levels for the drives, and the drive phi2 enable generator.
module iec_bus_hub #(
  parameter int NDEV        = 2,
  parameter int SYNC_STAGES = 3,
  parameter int FILT_LEN    = 4,
  parameter int DIV         = 32
) (
  input  logic            clk32,
  input  logic            reset_n,
  input  logic            host_atn_pull,
  input  logic            host_clk_pull,
  input  logic            host_data_pull,
  input  logic [NDEV-1:0] dev_en,
  input  logic [NDEV-1:0] dev_clk_pull,
  input  logic [NDEV-1:0] dev_data_pull,
  input  logic [NDEV-1:0] dev_atna,
  input  logic            turbo,
  output logic            bus_atn,
  output logic            bus_clk,
  output logic            bus_data,
  output logic            s_atn,
  output logic            s_clk,
  output logic            s_data,
  output logic            ph2_rise,
  output logic            ph2_fall
);

  // A drive holds DATA low while its ATNA bit disagrees with the current ATN state.
  logic [NDEV-1:0] atn_ack;

  assign bus_atn  = ~host_atn_pull;
  assign atn_ack  = dev_en & (dev_atna ^ {NDEV{~bus_atn}});
  assign bus_clk  = ~(host_clk_pull  | (|(dev_en & dev_clk_pull)));
  assign bus_data = ~(host_data_pull | (|(dev_en & (dev_data_pull | atn_ack))));

  // Line vector order: {data, clk, atn}.
  logic [2:0] bus_lvl;
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] synced;
  logic [2:0] filt_lvl;

  assign bus_lvl = {bus_data, bus_clk, bus_atn};

  // NOTE: every synchroniser stage is reset to "released" so the drives never see a
  // spurious low on the first cycles after reset; these are flops, not a RAM.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= bus_lvl;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign filt_lvl = synced;
    end else begin : g_filt
      localparam int              CW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
      localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_LEN - 1);

      logic [CW-1:0] cnt_q [3];
      logic [2:0]    out_q;

      // A line must disagree with the filtered level for FILT_LEN consecutive edges to flip it.
      always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
          out_q <= '1;
          for (int l = 0; l < 3; l++) cnt_q[l] <= '0;
        end else begin
          for (int l = 0; l < 3; l++) begin
            if (synced[l] == out_q[l]) begin
              cnt_q[l] <= '0;
            end else if (cnt_q[l] == CNT_LAST) begin
              out_q[l] <= synced[l];
              cnt_q[l] <= '0;
            end else begin
              cnt_q[l] <= cnt_q[l] + 1'b1;
            end
          end
        end
      end

      assign filt_lvl = out_q;
    end
  endgenerate

  assign {s_data, s_clk, s_atn} = filt_lvl;

  localparam int              CNTW    = $clog2(DIV);
  localparam logic [CNTW-1:0] LAST_1X = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] LAST_2X = CNTW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] MID_1X  = CNTW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] MID_2X  = CNTW'(DIV / 4 - 1);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_last;
  logic [CNTW-1:0] cnt_mid;
  logic            turbo_q;

  // The rate only changes on the wrap edge, so a period is never cut short or stretched.
  assign cnt_last = turbo_q ? LAST_2X : LAST_1X;
  assign cnt_mid  = turbo_q ? MID_2X  : MID_1X;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      turbo_q  <= 1'b0;
      ph2_rise <= 1'b0;
      ph2_fall <= 1'b0;
    end else begin
      ph2_rise <= (cnt_q == cnt_last);
      ph2_fall <= (cnt_q == cnt_mid);
      if (cnt_q == cnt_last) begin
        cnt_q   <= '0;
        turbo_q <= turbo;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iec_bus_hub.sv
// Bench for iec_bus_hub: a filtered build and a FILT_LEN=0 build share the stimulus and are
// compared every cycle against a history-based model, plus directed literal checks.
module tb_iec_bus_hub;

  localparam int NDEV = 2;
  localparam int SYNC = 3;
  localparam int FILT = 4;
  localparam int DIV  = 32;
  localparam int HLEN = 16;

  logic clk32 = 1'b0;
  logic reset_n;
  logic host_atn_pull, host_clk_pull, host_data_pull, turbo;
  logic [NDEV-1:0] dev_en, dev_clk_pull, dev_data_pull, dev_atna;

  logic bus_atn, bus_clk, bus_data, s_atn, s_clk, s_data, ph2_rise, ph2_fall;
  logic nf_bus_atn, nf_bus_clk, nf_bus_data, nf_s_atn, nf_s_clk, nf_s_data;
  logic nf_ph2_rise, nf_ph2_fall;

  int tests = 0;
  int fails = 0;

  always #5 clk32 = ~clk32;

  iec_bus_hub #(.NDEV(NDEV), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .DIV(DIV)) u_dut (
    .clk32(clk32), .reset_n(reset_n),
    .host_atn_pull(host_atn_pull), .host_clk_pull(host_clk_pull), .host_data_pull(host_data_pull),
    .dev_en(dev_en), .dev_clk_pull(dev_clk_pull), .dev_data_pull(dev_data_pull),
    .dev_atna(dev_atna), .turbo(turbo),
    .bus_atn(bus_atn), .bus_clk(bus_clk), .bus_data(bus_data),
    .s_atn(s_atn), .s_clk(s_clk), .s_data(s_data),
    .ph2_rise(ph2_rise), .ph2_fall(ph2_fall)
  );

  iec_bus_hub #(.NDEV(NDEV), .SYNC_STAGES(SYNC), .FILT_LEN(0), .DIV(DIV)) u_nf (
    .clk32(clk32), .reset_n(reset_n),
    .host_atn_pull(host_atn_pull), .host_clk_pull(host_clk_pull), .host_data_pull(host_data_pull),
    .dev_en(dev_en), .dev_clk_pull(dev_clk_pull), .dev_data_pull(dev_data_pull),
    .dev_atna(dev_atna), .turbo(turbo),
    .bus_atn(nf_bus_atn), .bus_clk(nf_bus_clk), .bus_data(nf_bus_data),
    .s_atn(nf_s_atn), .s_clk(nf_s_clk), .s_data(nf_s_data),
    .ph2_rise(nf_ph2_rise), .ph2_fall(nf_ph2_fall)
  );

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Line levels from the open-collector rules: a line is released unless someone pulls it.
  function automatic logic [2:0] bus_model();
    logic clk_rel;
    logic data_rel;
    clk_rel  = 1'b1;
    data_rel = 1'b1;
    if (host_clk_pull)  clk_rel  = 1'b0;
    if (host_data_pull) data_rel = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      if (dev_en[i]) begin
        if (dev_clk_pull[i])  clk_rel  = 1'b0;
        if (dev_data_pull[i]) data_rel = 1'b0;
        if (dev_atna[i] != host_atn_pull) data_rel = 1'b0;
      end
    end
    return {data_rel, clk_rel, ~host_atn_pull};
  endfunction

  // Model: hist[j] is the bus level sampled j edges ago; the filtered level flips once the
  // last FILT values seen through the synchroniser all disagree with it.
  logic [2:0] hist [$];
  logic [2:0] m_s, m_s_nf, hv;
  logic       m_rise, m_fall, all_diff;
  int         m_e, m_ps, m_p;

  always @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      hist = {};
      for (int i = 0; i < HLEN; i++) hist.push_back(3'b111);
      m_s    = 3'b111;
      m_s_nf = 3'b111;
      m_e    = 0;
      m_ps   = 0;
      m_p    = DIV;
      m_rise = 1'b0;
      m_fall = 1'b0;
    end else begin
      hist.push_front(bus_model());
      void'(hist.pop_back());
      for (int l = 0; l < 3; l++) begin
        all_diff = 1'b1;
        for (int k = 0; k < FILT; k++) begin
          hv = hist[SYNC + k];
          if (hv[l] == m_s[l]) all_diff = 1'b0;
        end
        if (all_diff) m_s[l] = ~m_s[l];
      end
      m_s_nf = hist[SYNC - 1];
      m_e++;
      m_rise = (m_e == m_ps + m_p);
      m_fall = (m_e == m_ps + m_p / 2);
      if (m_rise) begin
        m_ps = m_e;
        m_p  = turbo ? DIV / 2 : DIV;
      end
    end
  end

  always @(negedge clk32) begin
    logic [2:0] b;
    b = bus_model();
    check("bus_atn", bus_atn, b[0]);
    check("bus_clk", bus_clk, b[1]);
    check("bus_data", bus_data, b[2]);
    check("s_atn", s_atn, m_s[0]);
    check("s_clk", s_clk, m_s[1]);
    check("s_data", s_data, m_s[2]);
    check("ph2_rise", ph2_rise, m_rise);
    check("ph2_fall", ph2_fall, m_fall);
    check("nf_bus_data", nf_bus_data, b[2]);
    check("nf_s_atn", nf_s_atn, m_s_nf[0]);
    check("nf_s_clk", nf_s_clk, m_s_nf[1]);
    check("nf_s_data", nf_s_data, m_s_nf[2]);
    check("nf_ph2_rise", nf_ph2_rise, m_rise);
    check("nf_ph2_fall", nf_ph2_fall, m_fall);
  end

  task automatic next_cycle();
    @(posedge clk32);
    #2;
  endtask

  // c counts edges since reset release; literal checks sit at negedge+1.
  task automatic div_run(input int ncyc, input int turbo_at);
    for (int c = 1; c <= ncyc; c++) begin
      next_cycle();
      if (c == turbo_at) turbo = 1'b1;
      #4;
      if (c == 15)  check("lit_fall_15", ph2_fall, 1'b0);
      if (c == 16)  check("lit_fall_16", ph2_fall, 1'b1);
      if (c == 31)  check("lit_rise_31", ph2_rise, 1'b0);
      if (c == 32)  check("lit_rise_32", ph2_rise, 1'b1);
      if (c == 64)  check("lit_rise_64", ph2_rise, 1'b1);
      if (c == 96)  check("lit_rise_96", ph2_rise, 1'b1);
      if (c == 104) check("lit_turbo_fall_104", ph2_fall, 1'b1);
      if (c == 112) check("lit_turbo_rise_112", ph2_rise, 1'b1);
      if (c == 113) check("lit_turbo_rise_113", ph2_rise, 1'b0);
      if (c == 128) check("lit_turbo_rise_128", ph2_rise, 1'b1);
    end
  endtask

  initial begin
    host_atn_pull  = 1'b0;
    host_clk_pull  = 1'b0;
    host_data_pull = 1'b0;
    turbo          = 1'b0;
    dev_en         = 2'b11;
    dev_clk_pull   = 2'b00;
    dev_data_pull  = 2'b00;
    dev_atna       = 2'b00;
    reset_n        = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) next_cycle();
    check("rst_s_clk", s_clk, 1'b1);
    check("rst_ph2_rise", ph2_rise, 1'b0);
    check("rst_ph2_fall", ph2_fall, 1'b0);
    reset_n = 1'b1;

    // Two 1x periods, then turbo raised at cnt=74-64=10 of the third period.
    div_run(130, 74);
    turbo = 1'b0;

    // ATN auto-acknowledge, checked 1 time unit after each input change.
    next_cycle();
    host_atn_pull = 1'b1;
    dev_atna      = 2'b00;
    #1;
    check("ack_atn_low", bus_atn, 1'b0);
    check("ack_none", bus_data, 1'b0);
    next_cycle();
    dev_atna = 2'b01;
    #1 check("ack_one", bus_data, 1'b0);
    next_cycle();
    dev_atna = 2'b11;
    #1 check("ack_all", bus_data, 1'b1);
    next_cycle();
    dev_en   = 2'b01;
    dev_atna = 2'b01;
    #1 check("ack_disabled", bus_data, 1'b1);
    next_cycle();
    host_atn_pull = 1'b0;
    dev_atna      = 2'b00;
    dev_en        = 2'b11;
    #1 check("ack_idle", bus_data, 1'b1);
    repeat (10) next_cycle();

    // 3-cycle CLK pull is shorter than the filter and must not reach s_clk.
    host_clk_pull = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c == 3) host_clk_pull = 1'b0;
      #4 check("short_pulse", s_clk, 1'b1);
    end

    // 10-cycle CLK pull: s_clk falls 7 edges after the pull and rises 7 edges after release.
    host_clk_pull = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (c == 10) host_clk_pull = 1'b0;
      #4;
      if (c == 6)  check("long_pre", s_clk, 1'b1);
      if (c == 7)  check("long_fall", s_clk, 1'b0);
      if (c == 16) check("long_hold", s_clk, 1'b0);
      if (c == 17) check("long_rise", s_clk, 1'b1);
    end

    // 1-cycle drive CLK pull seen by the unfiltered build only, 3 edges later.
    dev_clk_pull = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 1) dev_clk_pull = 2'b00;
      #4;
      check("nf_pulse", nf_s_clk, (c == 3) ? 1'b0 : 1'b1);
      check("nf_pulse_filtered", s_clk, 1'b1);
    end

    // Reset asserted while the DATA filter is mid-count and ph2_rise is high.
    host_data_pull = 1'b1;
    repeat (10) next_cycle();
    for (int i = 0; i < 100 && (m_ps + m_p - m_e) != 5; i++) next_cycle();
    check("sched_found", ((m_ps + m_p - m_e) == 5), 1'b1);
    host_data_pull = 1'b0;
    repeat (5) next_cycle();
    #1;
    check("pre_rst_rise", ph2_rise, 1'b1);
    check("pre_rst_s_data", s_data, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_s_atn", s_atn, 1'b1);
    check("mid_rst_s_clk", s_clk, 1'b1);
    check("mid_rst_s_data", s_data, 1'b1);
    check("mid_rst_rise", ph2_rise, 1'b0);
    check("mid_rst_fall", ph2_fall, 1'b0);
    check("mid_rst_nf_s_data", nf_s_data, 1'b1);
    repeat (2) next_cycle();
    reset_n = 1'b1;
    div_run(40, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iec_bus_hub.md
# iec_bus_hub

Parametrised IEC serial-bus hub and drive clock-enable generator for multi-drive configurations. Forms the open-collector wired-AND of the host and up to NDEV drive-side pulls, including per-drive hardware ATN auto-acknowledge. Delivers synchronised, glitch-filtered bus levels to each drive's VIA inputs. Generates the drive-side phi2 rising/falling enables with a selectable 1x/2x (turbo) rate.

## Interface
- NDEV, 2: number of drive ports, 1..4
- SYNC_STAGES, 3: synchroniser depth on bus levels, 2..4
- FILT_LEN, 4: glitch filter length in clk32 cycles, 0..15; 0 bypasses the filter
- DIV, 32: clk32 cycles per drive phi2 period at 1x rate; even, 4..64

- clk32  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- host_atn_pull / host_clk_pull / host_data_pull  in  1 each  host pulls line low when 1
- dev_en  in  NDEV  drive present; pulls of a disabled drive are ignored
- dev_clk_pull / dev_data_pull  in  NDEV  drive pulls line low when 1
- dev_atna  in  NDEV  drive ATN-acknowledge bit (VIA PB4)
- turbo  in  1  1 = phi2 period DIV/2
- bus_atn / bus_clk / bus_data  out  1 each  raw wired-AND line levels, 1 = released
- s_atn / s_clk / s_data  out  1 each  synchronised, filtered levels, 1 = released
- ph2_rise / ph2_fall  out  1 each  one-clk32 enable pulses

## Operation
- Auto-ack pull for drive i: `dev_en[i] & (dev_atna[i] ^ ~bus_atn)`.
- bus_atn = ~host_atn_pull.
- bus_clk = ~(host_clk_pull | OR over i of (dev_en[i] & dev_clk_pull[i])).
- bus_data = ~(host_data_pull | OR over i of (dev_en[i] & (dev_data_pull[i] | auto-ack pull))).
- Bus outputs are combinational, matching real open-collector behaviour. No register sits on the host-visible path.
- Synchroniser: each bus line passes through SYNC_STAGES flops.
- Glitch filter, per line:
  - Holds a count of 0..FILT_LEN-1.
  - While the synced value ≠ the filtered output, the count increments.
  - On the edge where the count = FILT_LEN-1 and the values still differ, the output takes the synced value and the count clears.
  - Any cycle with synced = output clears the count.
  - FILT_LEN=0: output = last synchroniser stage.
- Divider:
  - Counter cnt runs 0..P-1 and wraps. P = DIV at 1x, DIV/2 when the latched turbo mode is active.
  - turbo is sampled only on the edge where cnt = P-1 (wrap edge). A mid-period change never produces a short or long period other than the old P.
- Enables are registered:
  - ph2_rise <= (cnt == P-1): high while cnt = 0.
  - ph2_fall <= (cnt == P/2-1): high while cnt = P/2.
  - The two enables are never high in the same cycle.

## Timing
- Reset (reset_n low, async):
  - All synchroniser flops, filter outputs and s_* = 1.
  - Filter counts = 0, cnt = 0, turbo latch = 0, ph2_rise = ph2_fall = 0.
  - bus_* remain combinational functions of the inputs during reset.
- Reset mid-period truncates the period. After release, cnt starts at 0 with ph2_rise low. The first ph2_fall comes at cycle DIV/2 (1x), and the first ph2_rise P cycles after release.
- s_* latency from a stable bus change:
  - FILT_LEN>0: SYNC_STAGES + FILT_LEN clk32 edges.
  - FILT_LEN=0: SYNC_STAGES edges.
- A pulse shorter than FILT_LEN cycles at the synchroniser output never reaches s_*.
- Auto-ack: bus_data responds to a host ATN change in the same cycle (zero clk32 latency).
- turbo takes effect on the first full period after the next wrap edge.

## Test plan
- Reset release, DIV=32, turbo=0 -> ph2_fall first at cycle 16, ph2_rise first at cycle 32, then every 32 cycles; enables are 1 cycle wide and never coincident.
- Drive turbo 0->1 at cnt=10 -> the current period completes at 32 cycles, following periods are 16 cycles, with ph2_fall at cnt=8.
- host_atn_pull=1 with dev_en=2'b11 and dev_atna=0 -> bus_data=0 in the same cycle. Set dev_atna=2'b01: bus_data stays 0. Set dev_atna=2'b11: bus_data=1. Set dev_en[1]=0 with dev_atna[1]=0: bus_data=1.
- host_clk_pull high for 3 cycles (FILT_LEN=4, SYNC_STAGES=3) -> s_clk stays 1. A 10-cycle pull -> s_clk=0 exactly 7 edges after the pull, and back to 1 seven edges after release.
- FILT_LEN=0 build: a 1-cycle dev_clk_pull[0] pulse -> s_clk low for exactly 1 cycle, 3 edges later.
- Assert reset_n low mid-filter-count and mid-period -> s_*=1 and ph2_*=0 immediately. After release, the divider sequence matches the first scenario.
